cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 14 +
 rtl/cdb_arbiter_rr_pick.sv | 29 ++
 rtl/cdb_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: bus count, arbiter
// address type and the FSM state encoding.
package cdb_arbiter_pkg;

  localparam int BUS_COUNT = 2;

  typedef logic [7:0] arb_addr_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Circular priority picker: returns the first set bit of vec at or after
// index start, wrapping past N-1 back to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    int            pos;
    logic [IW-1:0] p;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    p     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos   = (int'(start) + k >= N) ? (int'(start) + k - N) : (int'(start) + k);
      p     = IW'(pos);
      found = found | vec[p];
      idx   = vec[p] ? p : idx;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-bus round-robin arbiter for combos sharing the common data buses.
// Optional feature macro: CDB_ARBITER_STARVATION_EN (wait counters and
// starvation priority); without it arbitration is pure round-robin.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int        REQUESTERS   = 4,
  parameter logic [7:0] BASE_ADDRESS = 8'h00,
  parameter int        MAX_WAIT     = 15
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [REQUESTERS-1:0]       request,
  input  logic [BUS_COUNT-1:0]        bus_hold,
  output logic [REQUESTERS-1:0]       grant,
  output arb_addr_t [BUS_COUNT-1:0]   bus_select,
  output logic [BUS_COUNT-1:0]        bus_valid,
  output logic [REQUESTERS-1:0]       starved
);

  localparam int IW = $clog2(REQUESTERS);

  if (REQUESTERS < 2 || REQUESTERS > 8 || MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_param_check
    $error("cdb_arbiter: parameter out of range");
  end

  function automatic logic [REQUESTERS-1:0] onehot(input logic [IW-1:0] i);
    onehot = {{(REQUESTERS-1){1'b0}}, 1'b1} << i;
  endfunction

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    wrap_inc = (i == IW'(REQUESTERS - 1)) ? '0 : i + IW'(1);
  endfunction

  arb_state_t                         state_r;
  logic [IW-1:0]                      ptr_r;
  logic [IW-1:0]                      last_idx_r;
  logic [REQUESTERS-1:0]              grant_r;
  arb_addr_t [BUS_COUNT-1:0]          bus_select_r;
  logic [BUS_COUNT-1:0]               bus_valid_r;

  logic [IW-1:0]                      cur_ptr_s;
  logic [REQUESTERS-1:0]              eligible_s;
  logic [REQUESTERS-1:0]              prio_s;
  logic [REQUESTERS-1:0]              vec0_s;
  logic [REQUESTERS-1:0]              vec1_s;
  logic [IW-1:0]                      start0_s;
  logic [IW-1:0]                      start1_s;
  logic                               found0_s;
  logic                               found1_s;
  logic [IW-1:0]                      idx0_s;
  logic [IW-1:0]                      idx1_s;
  logic [BUS_COUNT-1:0]               valid_s;
  logic [BUS_COUNT-1:0][IW-1:0]       bus_idx_s;
  logic [IW-1:0]                      last_s;
  logic [REQUESTERS-1:0]              grant_s;
  logic                               any_s;

  assign eligible_s = request & ~grant_r;

`ifdef CDB_ARBITER_STARVATION_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic [REQUESTERS-1:0][7:0] wait_cnt_r;
  logic [REQUESTERS-1:0][7:0] wait_next_s;
  logic [REQUESTERS-1:0]      starved_r;
  logic [REQUESTERS-1:0]      starved_next_s;

  // Wait counters run only while a request is pending and not being served.
  always_comb begin
    wait_next_s    = '0;
    starved_next_s = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (!request[i] || grant_r[i]) begin
        wait_next_s[i] = 8'h00;
      end else if (wait_cnt_r[i] < WAIT_LIMIT) begin
        wait_next_s[i] = wait_cnt_r[i] + 8'h01;
      end else begin
        wait_next_s[i] = wait_cnt_r[i];
      end
      starved_next_s[i] = (wait_next_s[i] >= WAIT_LIMIT);
    end
  end

  // Wait counter and starvation flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_r <= '0;
      starved_r  <= '0;
    end else begin
      wait_cnt_r <= wait_next_s;
      starved_r  <= starved_next_s;
    end
  end

  assign prio_s  = eligible_s & starved_r;
  assign starved = starved_r;
`else
  assign prio_s  = '0;
  assign starved = '0;
`endif

  // Pointer in effect this cycle: follows the last grant when one was issued.
  always_comb begin
    if (state_r == ST_ACTIVE) begin
      cur_ptr_s = wrap_inc(last_idx_r);
    end else begin
      cur_ptr_s = ptr_r;
    end
  end

  // A starved requester preempts the round-robin first pick; the second
  // pick then resumes round-robin order from the pointer.
  always_comb begin
    if (|prio_s) begin
      vec0_s   = prio_s;
      start0_s = '0;
      start1_s = cur_ptr_s;
    end else begin
      vec0_s   = eligible_s;
      start0_s = cur_ptr_s;
      start1_s = wrap_inc(idx0_s);
    end
    vec1_s = eligible_s & ~onehot(idx0_s);
  end

  rr_pick #(.N(REQUESTERS), .IW(IW)) u_pick_bus0 (
    .vec   (vec0_s),
    .start (start0_s),
    .found (found0_s),
    .idx   (idx0_s)
  );

  rr_pick #(.N(REQUESTERS), .IW(IW)) u_pick_bus1 (
    .vec   (vec1_s),
    .start (start1_s),
    .found (found1_s),
    .idx   (idx1_s)
  );

  // Map picks onto free buses; a held bus shifts the first pick to the other.
  always_comb begin
    valid_s   = 2'b00;
    bus_idx_s = '0;
    case (bus_hold)
      2'b00: begin
        valid_s[0]   = found0_s;
        bus_idx_s[0] = idx0_s;
        valid_s[1]   = found0_s & found1_s;
        bus_idx_s[1] = idx1_s;
      end
      2'b01: begin
        valid_s[1]   = found0_s;
        bus_idx_s[1] = idx0_s;
      end
      2'b10: begin
        valid_s[0]   = found0_s;
        bus_idx_s[0] = idx0_s;
      end
      default: begin
        valid_s   = 2'b00;
        bus_idx_s = '0;
      end
    endcase
    last_s  = valid_s[1] ? bus_idx_s[1] : bus_idx_s[0];
    any_s   = |valid_s;
    grant_s = (valid_s[0] ? onehot(bus_idx_s[0]) : '0) |
              (valid_s[1] ? onehot(bus_idx_s[1]) : '0);
  end

  // Registered outputs, pointer bookkeeping and FSM advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_r      <= '0;
      bus_valid_r  <= 2'b00;
      bus_select_r <= '0;
      state_r      <= ST_IDLE;
      last_idx_r   <= '0;
      ptr_r        <= '0;
    end else begin
      grant_r         <= grant_s;
      bus_valid_r     <= valid_s;
      bus_select_r[0] <= valid_s[0] ? (BASE_ADDRESS + arb_addr_t'(bus_idx_s[0])) : 8'h00;
      bus_select_r[1] <= valid_s[1] ? (BASE_ADDRESS + arb_addr_t'(bus_idx_s[1])) : 8'h00;
      state_r         <= any_s ? ST_ACTIVE : ST_IDLE;
      last_idx_r      <= last_s;
      ptr_r           <= cur_ptr_s;
    end
  end

  assign grant      = grant_r;
  assign bus_valid  = bus_valid_r;
  assign bus_select = bus_select_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: randomized requests/holds, expectations
// from a list-based reference model, checked by an independent monitor.
module tb_cdb_arbiter;

  localparam int         R    = 4;
  localparam logic [7:0] BASE = 8'hFE;
  localparam int         MW   = 3;
  localparam int         NCYC = 480;
`ifdef CDB_ARBITER_STARVATION_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic [R-1:0]    request;
  logic [1:0]      bus_hold;
  logic [R-1:0]    grant;
  logic [1:0][7:0] bus_select;
  logic [1:0]      bus_valid;
  logic [R-1:0]    starved;

  cdb_arbiter #(.REQUESTERS(R), .BASE_ADDRESS(BASE), .MAX_WAIT(MW)) dut (
    .clock      (clock),
    .reset      (reset),
    .request    (request),
    .bus_hold   (bus_hold),
    .grant      (grant),
    .bus_select (bus_select),
    .bus_valid  (bus_valid),
    .starved    (starved)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [R-1:0] grant;
    logic [1:0]   valid;
    logic [15:0]  sel;
    logic [R-1:0] starved;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   running    = 1'b1;

  int           m_ptr;
  logic [R-1:0] m_grant;
  logic [R-1:0] m_starved;
  int           m_cnt[R];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Reference: order eligible requesters circularly from the pointer, pull the
  // lowest starved one to the front, then hand them to free buses in order.
  task automatic model_step();
    exp_t e;
    int   cand[$];
    int   buses[$];
    int   last;
    int   s;
    e = '0;
    if (reset) begin
      m_ptr = 0; m_grant = '0; m_starved = '0;
      for (int i = 0; i < R; i++) m_cnt[i] = 0;
      exp_q.push_back(e);
      return;
    end
    for (int k = 0; k < R; k++) begin
      int i = (m_ptr + k) % R;
      if (request[i] && !m_grant[i]) cand.push_back(i);
    end
    s = -1;
    for (int i = R - 1; i >= 0; i--)
      if (STARVE && request[i] && !m_grant[i] && m_starved[i]) s = i;
    if (s >= 0) begin
      for (int j = 0; j < cand.size(); j++)
        if (cand[j] == s) begin cand.delete(j); break; end
      cand.push_front(s);
    end
    for (int b = 0; b < 2; b++) if (!bus_hold[b]) buses.push_back(b);
    last = -1;
    for (int k = 0; k < cand.size() && k < buses.size(); k++) begin
      e.grant[cand[k]] = 1'b1;
      e.valid[buses[k]] = 1'b1;
      e.sel[buses[k]*8 +: 8] = 8'((int'(BASE) + cand[k]) % 256);
      last = cand[k];
    end
    for (int i = 0; i < R; i++) begin
      if (!request[i] || m_grant[i]) m_cnt[i] = 0;
      else if (m_cnt[i] < MW) m_cnt[i]++;
      m_starved[i] = STARVE && (m_cnt[i] >= MW);
    end
    e.starved = m_starved;
    if (last >= 0) m_ptr = (last + 1) % R;
    m_grant = e.grant;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  always @(posedge clock) begin : monitor
    exp_t e;
    #1;
    if (running) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL scoreboard_underflow at %0t: got 0 entries, expected 1", $time);
      end else begin
        e = exp_q.pop_front();
        check("grant", 32'(grant), 32'(e.grant));
        check("bus_valid", 32'(bus_valid), 32'(e.valid));
        check("bus_select", 32'(bus_select), 32'(e.sel));
        check("starved", 32'(starved), 32'(e.starved));
      end
    end
  end

  initial begin
    reset = 1'b1; request = '1; bus_hold = 2'b00;
    model_step();
    for (int c = 1; c < NCYC; c++) begin
      @(negedge clock);
      if ((c / 40) % 3 == 1) begin
        request  = '1;
        bus_hold = ((c / 40) % 2 == 1) ? 2'b10 : 2'b00;
      end else begin
        request  = R'($urandom) | R'($urandom);
        bus_hold = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      end
      reset = (c < 3) || (c >= 200 && c < 202);
      if (reset) request = '1;
      model_step();
    end
    @(posedge clock);
    #2;
    running = 1'b0;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
